// File: rtl/pulse_ramp.sv
// Period ramp controller: walks a pulse period from an idle value down to a
// cruise target and back, one step per downstream tick.
module pulse_ramp #(
   parameter logic [31:0] START_TIME = 32'd2000000,
   parameter logic [31:0] MIN_TIME   = 32'd1000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        tick,
   input  logic        start,
   input  logic        stop,
   input  logic [31:0] target_time,
   input  logic [15:0] step,
   output logic [31:0] pulse_time,
   output logic        busy,
   output logic        at_speed,
   output logic        done
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ACCEL  = 2'd1;
   localparam logic [1:0] S_CRUISE = 2'd2;
   localparam logic [1:0] S_DECEL  = 2'd3;

   logic [1:0]  r_state;
   logic [31:0] r_pulse;
   logic [31:0] r_tgt;
   logic [31:0] r_step;
   logic        r_busy;
   logic        r_at_speed;
   logic        r_done;

   logic [1:0]  w_state_nxt;
   logic [31:0] w_pulse_nxt;
   logic [31:0] w_tgt_nxt;
   logic [31:0] w_step_nxt;
   logic [31:0] w_tgt_in;
   logic [31:0] w_step_in;
   logic [32:0] w_gap_dn;
   logic [32:0] w_gap_up;
   logic [32:0] w_step33;
   logic        w_dn_room;
   logic        w_up_room;
   logic        w_accept;

   always_comb begin
      w_tgt_in = target_time;
      if (target_time < MIN_TIME)
         w_tgt_in = MIN_TIME;
      else if (target_time > START_TIME)
         w_tgt_in = START_TIME;
   end

   assign w_step_in = (step == 16'd0) ? 32'd1 : {16'd0, step};
   assign w_accept  = start && !stop;

   // Distances to either end are taken in 33 bits so a step larger
   // than the remaining gap saturates instead of wrapping.
   assign w_step33  = {1'b0, r_step};
   assign w_gap_dn  = {1'b0, r_pulse} - {1'b0, r_tgt};
   assign w_gap_up  = {1'b0, START_TIME} - {1'b0, r_pulse};
   assign w_dn_room = w_gap_dn > w_step33;
   assign w_up_room = w_gap_up > w_step33;

   always_comb begin
      w_state_nxt = r_state;
      w_pulse_nxt = r_pulse;
      w_tgt_nxt   = r_tgt;
      w_step_nxt  = r_step;
      unique case (r_state)
         S_IDLE: begin
            w_pulse_nxt = START_TIME;
            if (w_accept) begin
               w_tgt_nxt   = w_tgt_in;
               w_step_nxt  = w_step_in;
               w_state_nxt = S_ACCEL;
            end
         end
         S_ACCEL: begin
            if (stop) begin
               w_state_nxt = S_DECEL;
            end else if (tick) begin
               if (w_dn_room) begin
                  w_pulse_nxt = r_pulse - r_step;
               end else begin
                  w_pulse_nxt = r_tgt;
                  w_state_nxt = S_CRUISE;
               end
            end
         end
         S_CRUISE: begin
            if (stop)
               w_state_nxt = S_DECEL;
         end
         S_DECEL: begin
            if (tick) begin
               if (w_up_room) begin
                  w_pulse_nxt = r_pulse + r_step;
               end else begin
                  w_pulse_nxt = START_TIME;
                  w_state_nxt = S_IDLE;
               end
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_pulse_nxt = START_TIME;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_pulse    <= START_TIME;
         r_tgt      <= 32'd0;
         r_step     <= 32'd0;
         r_busy     <= 1'b0;
         r_at_speed <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_pulse    <= w_pulse_nxt;
         r_tgt      <= w_tgt_nxt;
         r_step     <= w_step_nxt;
         r_busy     <= (w_state_nxt != S_IDLE);
         r_at_speed <= (w_state_nxt == S_CRUISE);
         r_done     <= (r_state == S_DECEL) && (w_state_nxt == S_IDLE);
      end
   end

   assign pulse_time = r_pulse;
   assign busy       = r_busy;
   assign at_speed   = r_at_speed;
   assign done       = r_done;

endmodule

// File: tb/tb_pulse_ramp.sv
// Scoreboard bench for pulse_ramp: directed ramp scenarios plus random
// traffic against a rule-level reference model.
module tb_pulse_ramp;

   localparam longint ST = 100;
   localparam longint MN = 10;

   typedef enum int {M_IDLE, M_ACCEL, M_CRUISE, M_DECEL} mode_t;

   typedef struct {
      int unsigned due;
      logic [31:0] pt;
      logic        b;
      logic        a;
      logic        d;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        tick = 1'b0;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic [31:0] target_time = 32'd0;
   logic [15:0] step = 16'd0;
   logic [31:0] pulse_time;
   logic        busy;
   logic        at_speed;
   logic        done;

   int unsigned cyc = 0;
   int          n_chk = 0;
   int          n_pass = 0;
   exp_t        q[$];
   exp_t        e;

   mode_t  m_mode;
   longint m_pulse;
   longint m_tgt;
   longint m_stp;
   bit     m_done;

   pulse_ramp #(
      .START_TIME(32'd100),
      .MIN_TIME  (32'd10)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .tick       (tick),
      .start      (start),
      .stop       (stop),
      .target_time(target_time),
      .step       (step),
      .pulse_time (pulse_time),
      .busy       (busy),
      .at_speed   (at_speed),
      .done       (done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: compares every DUT output cycle that has a queued expectation.
   always @(negedge clk) begin
      while (q.size() > 0 && q[0].due <= cyc) begin
         e = q.pop_front();
         n_chk++;
         if (pulse_time === e.pt && busy === e.b &&
             at_speed === e.a && done === e.d)
            n_pass++;
         else
            $display("FAIL cycle%0d: got pt=%0d b=%0b a=%0b d=%0b want pt=%0d b=%0b a=%0b d=%0b",
                     cyc, pulse_time, busy, at_speed, done,
                     e.pt, e.b, e.a, e.d);
      end
   end

   task automatic push_exp(int unsigned due);
      exp_t x;
      x.due = due;
      x.pt  = m_pulse[31:0];
      x.b   = (m_mode != M_IDLE);
      x.a   = (m_mode == M_CRUISE);
      x.d   = m_done;
      q.push_back(x);
   endtask

   task automatic model_reset();
      m_mode  = M_IDLE;
      m_pulse = ST;
      m_tgt   = 0;
      m_stp   = 0;
      m_done  = 0;
   endtask

   task automatic model(bit st, bit sp, bit tk, logic [31:0] tt,
                        logic [15:0] s);
      longint t;
      m_done = 0;
      case (m_mode)
         M_IDLE: if (st && !sp) begin
            t = tt;
            m_tgt  = (t < MN) ? MN : ((t > ST) ? ST : t);
            m_stp  = (s == 0) ? 1 : s;
            m_mode = M_ACCEL;
         end
         M_ACCEL: begin
            if (sp) m_mode = M_DECEL;
            else if (tk) begin
               if (m_pulse - m_tgt > m_stp) m_pulse = m_pulse - m_stp;
               else begin
                  m_pulse = m_tgt;
                  m_mode  = M_CRUISE;
               end
            end
         end
         M_CRUISE: if (sp) m_mode = M_DECEL;
         M_DECEL: if (tk) begin
            if (ST - m_pulse > m_stp) m_pulse = m_pulse + m_stp;
            else begin
               m_pulse = ST;
               m_mode  = M_IDLE;
               m_done  = 1;
            end
         end
         default: m_mode = M_IDLE;
      endcase
   endtask

   task automatic drive(bit st, bit sp, bit tk, logic [31:0] tt,
                        logic [15:0] s);
      start = st;
      stop = sp;
      tick = tk;
      target_time = tt;
      step = s;
      model(st, sp, tk, tt, s);
      push_exp(cyc + 1);
      @(posedge clk);
      #1;
      start = 1'b0;
      stop = 1'b0;
      tick = 1'b0;
   endtask

   task automatic idle(int n);
      for (int i = 0; i < n; i++) drive(0, 0, 0, 32'd0, 16'd0);
   endtask

   task automatic ticks(int n);
      for (int i = 0; i < n; i++) begin
         drive(0, 0, 1, 32'd0, 16'd0);
         idle(1);
      end
   endtask

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exv);
      n_chk++;
      if (act === exv) n_pass++;
      else $display("FAIL %s: got %0d want %0d", nm, act, exv);
   endtask

   task automatic do_reset();
      @(negedge clk);
      #1;
      start = 1'b0;
      stop = 1'b0;
      tick = 1'b0;
      rst = 1'b1;
      model_reset();
      push_exp(cyc);
      @(posedge clk);
      #1;
      push_exp(cyc);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_pulse", pulse_time, 32'd100);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_at_speed", {31'd0, at_speed}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      rst = 1'b0;
      idle(2);

      // basic ramp 70 / 10
      drive(1, 0, 0, 32'd70, 16'd10);
      ticks(3);
      chk("basic_cruise_pt", pulse_time, 32'd70);
      chk("basic_at_speed", {31'd0, at_speed}, 32'd1);
      drive(0, 1, 0, 32'd0, 16'd0);
      ticks(2);
      drive(0, 0, 1, 32'd0, 16'd0);
      chk("basic_done", {31'd0, done}, 32'd1);
      chk("basic_busy_low", {31'd0, busy}, 32'd0);
      idle(1);
      chk("basic_done_once", {31'd0, done}, 32'd0);

      // saturating step 7
      drive(1, 0, 0, 32'd70, 16'd7);
      ticks(4);
      chk("sat_pt72", pulse_time, 32'd72);
      chk("sat_not_yet", {31'd0, at_speed}, 32'd0);
      ticks(1);
      chk("sat_pt70", pulse_time, 32'd70);
      drive(0, 1, 0, 32'd0, 16'd0);
      ticks(5);

      // clamp low and high
      drive(1, 0, 0, 32'd5, 16'd30);
      ticks(3);
      chk("clamp_lo", pulse_time, 32'd10);
      drive(0, 1, 0, 32'd0, 16'd0);
      ticks(3);
      drive(1, 0, 0, 32'd500, 16'd10);
      ticks(1);
      chk("clamp_hi_pt", pulse_time, 32'd100);
      chk("clamp_hi_cruise", {31'd0, at_speed}, 32'd1);
      drive(0, 1, 0, 32'd0, 16'd0);
      ticks(1);

      // early stop with simultaneous tick
      drive(1, 0, 0, 32'd70, 16'd10);
      ticks(2);
      drive(0, 1, 1, 32'd0, 16'd0);
      chk("early_hold", pulse_time, 32'd80);
      ticks(2);

      // step 0, start while busy, start+tick, start+stop in idle
      drive(1, 0, 1, 32'd95, 16'd0);
      chk("start_tick", pulse_time, 32'd100);
      ticks(3);
      chk("step0", pulse_time, 32'd97);
      drive(1, 0, 0, 32'd10, 16'd50);
      ticks(1);
      chk("busy_start_ign", pulse_time, 32'd96);
      drive(0, 1, 0, 32'd0, 16'd0);
      ticks(4);
      drive(1, 1, 0, 32'd70, 16'd10);
      chk("start_stop_idle", {31'd0, busy}, 32'd0);
      idle(1);

      // reset abort in DECEL at 90
      drive(1, 0, 0, 32'd70, 16'd10);
      ticks(3);
      drive(0, 1, 0, 32'd0, 16'd0);
      ticks(2);
      chk("decel_90", pulse_time, 32'd90);
      do_reset();
      chk("abort_pt", pulse_time, 32'd100);
      idle(3);

      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 999) < 3)
            do_reset();
         else
            drive($urandom_range(0, 19) == 0, $urandom_range(0, 39) == 0,
                  $urandom_range(0, 2) == 0, 32'($urandom_range(0, 150)),
                  16'($urandom_range(0, 25)));
      end

      idle(2);
      @(negedge clk);
      #1;
      n_chk++;
      if (q.size() == 0) n_pass++;
      else $display("FAIL drain: %0d expectations left, want 0", q.size());
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
